// File: rtl/vga_pkg.sv
// Purpose: shared 640x480@60 raster geometry and pixel type for the frame-buffer path.
// Latency: n/a (package only).
// Backpressure: n/a. Used by both the scanout (read) side and the frame-buffer write side.
package vga_pkg;

   // Horizontal timing, in pixel clocks.
   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   // Vertical timing, in lines.
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int COLOR_DEPTH = 8;
   localparam int ADDR_W      = 19;
   localparam int FB_DEPTH    = H_ACTIVE * V_ACTIVE;

   typedef struct packed {
      logic [COLOR_DEPTH-1:0] r;
      logic [COLOR_DEPTH-1:0] g;
      logic [COLOR_DEPTH-1:0] b;
   } rgb_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Purpose: free-running h/v raster counters with stage-0 de/hs/vs flags and frame_start.
// Latency: flags are combinational from the counters; frame_start is registered (high while counters read 0,0).
// Backpressure: none; the raster never stalls.
// Ports: clk_i/rst_ni clock and async active-low reset; de0_o/hs0_o/vs0_o stage-0 flags
//        (hs/vs active low); eof_o high on the last counter state of a frame; frame_start_o pulse.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_FP     = vga_pkg::H_FP,
   parameter int H_SYNC   = vga_pkg::H_SYNC,
   parameter int H_BP     = vga_pkg::H_BP,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_FP     = vga_pkg::V_FP,
   parameter int V_SYNC   = vga_pkg::V_SYNC,
   parameter int V_BP     = vga_pkg::V_BP
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic de0_o,
   output logic hs0_o,
   output logic vs0_o,
   output logic eof_o,
   output logic frame_start_o
);

   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(HT);
   localparam int VW = $clog2(VT);

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          frame_start_q;
   logic          h_last, v_last;

   assign h_last = (h_cnt_q == HW'(HT - 1));
   assign v_last = (v_cnt_q == VW'(VT - 1));

   always_comb begin
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_last) begin
         h_cnt_d = '0;
         v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         frame_start_q <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         // Registered off the last state, so it is high while the counters read (0,0)
         // and never fires for the first frame after reset.
         frame_start_q <= h_last && v_last;
      end
   end

   assign de0_o = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
   assign hs0_o = !((h_cnt_q >= HW'(H_ACTIVE + H_FP)) &&
                    (h_cnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC)));
   assign vs0_o = !((v_cnt_q >= VW'(V_ACTIVE + V_FP)) &&
                    (v_cnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC)));
   assign eof_o         = h_last && v_last;
   assign frame_start_o = frame_start_q;

endmodule

// File: rtl/vga_scanout.sv
// Purpose: VGA read side: raster-order frame-buffer addressing, RAM-latency alignment, pin registers.
// Latency: RAM_LATENCY+1 cycles from counter state to all pins (frame_start is not delayed).
// Backpressure: none; RAM must return data exactly RAM_LATENCY (1..4) cycles after rd_addr.
// Ports: vga_clk/reset_n clock and async active-low reset; rd_addr/rd_data frame-buffer RAM
//        read port ({R,G,B}); vga_* DAC/connector pins; frame_start pulse at raster origin.
module vga_scanout
   import vga_pkg::*;
#(
   parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
   parameter int H_FP        = vga_pkg::H_FP,
   parameter int H_SYNC      = vga_pkg::H_SYNC,
   parameter int H_BP        = vga_pkg::H_BP,
   parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
   parameter int V_FP        = vga_pkg::V_FP,
   parameter int V_SYNC      = vga_pkg::V_SYNC,
   parameter int V_BP        = vga_pkg::V_BP,
   parameter int ADDR_W      = vga_pkg::ADDR_W,
   parameter int RAM_LATENCY = 2
) (
   input  logic                     vga_clk,
   input  logic                     reset_n,
   output logic [ADDR_W-1:0]        rd_addr,
   input  logic [3*COLOR_DEPTH-1:0] rd_data,
   output logic [COLOR_DEPTH-1:0]   vga_r,
   output logic [COLOR_DEPTH-1:0]   vga_g,
   output logic [COLOR_DEPTH-1:0]   vga_b,
   output logic                     vga_hs,
   output logic                     vga_vs,
   output logic                     vga_blank_n,
   output logic                     vga_sync_n,
   output logic                     frame_start
);

   localparam int L = RAM_LATENCY;

   logic de0, hs0, vs0, eof;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk_i         (vga_clk),
      .rst_ni        (reset_n),
      .de0_o         (de0),
      .hs0_o         (hs0),
      .vs0_o         (vs0),
      .eof_o         (eof),
      .frame_start_o (frame_start)
   );

   // Address counter: advances only on visible pixels, so during blanking it already
   // holds the next pixel to fetch. Running count replaces y*H_ACTIVE+x (no multiplier).
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

   always_comb begin
      rd_addr_d = rd_addr_q;
      if (eof) begin
         rd_addr_d = '0;
      end else if (de0) begin
         rd_addr_d = rd_addr_q + 1'b1;
      end
   end

   // Alignment pipe: flags travel alongside the RAM read so they meet rd_data.
   logic [L-1:0] de_pipe_q, hs_pipe_q, vs_pipe_q;
   rgb_t         rgb_q, rgb_d;
   logic         hs_q, vs_q, blank_n_q;

   // Blanked pixels are zeroed regardless of what the RAM returns.
   assign rgb_d = de_pipe_q[L-1] ? rgb_t'(rd_data) : '0;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_addr_q <= '0;
         de_pipe_q <= '0;
         hs_pipe_q <= '1;
         vs_pipe_q <= '1;
         rgb_q     <= '0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
      end else begin
         rd_addr_q    <= rd_addr_d;
         de_pipe_q[0] <= de0;
         hs_pipe_q[0] <= hs0;
         vs_pipe_q[0] <= vs0;
         for (int i = 1; i < L; i++) begin
            de_pipe_q[i] <= de_pipe_q[i-1];
            hs_pipe_q[i] <= hs_pipe_q[i-1];
            vs_pipe_q[i] <= vs_pipe_q[i-1];
         end
         rgb_q     <= rgb_d;
         hs_q      <= hs_pipe_q[L-1];
         vs_q      <= vs_pipe_q[L-1];
         blank_n_q <= de_pipe_q[L-1];
      end
   end

   assign rd_addr     = rd_addr_q;
   assign vga_r       = rgb_q.r;
   assign vga_g       = rgb_q.g;
   assign vga_b       = rgb_q.b;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_blank_n = blank_n_q;
   assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_scanout.sv
// Purpose: self-checking bench for vga_scanout: full 640x480 geometry plus reduced geometries at RAM latency 1/2/4.
// Latency: expected pins are queued per cycle and popped RAM_LATENCY+1 cycles later by the monitor.
// Backpressure: n/a; the RAM model echoes {5'b0,addr} for visible pixels and junk (all-ones or X) otherwise.
module tb_vga_scanout;

   localparam int NI = 4;
   // Instance 0 is full-size; 1..3 use a 25x11 raster (16x6 visible) so whole frames fit.
   localparam int HA_P  [NI] = '{640, 16, 16, 16};
   localparam int HF_P  [NI] = '{16, 2, 2, 2};
   localparam int HS_P  [NI] = '{96, 4, 4, 4};
   localparam int HB_P  [NI] = '{48, 3, 3, 3};
   localparam int VA_P  [NI] = '{480, 6, 6, 6};
   localparam int VF_P  [NI] = '{10, 2, 2, 2};
   localparam int VS_P  [NI] = '{2, 2, 2, 2};
   localparam int VB_P  [NI] = '{33, 1, 1, 1};
   localparam int LAT_P [NI] = '{2, 1, 2, 4};
   localparam bit FILLX_P [NI] = '{1'b0, 1'b1, 1'b0, 1'b1};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [18:0] addr_a [NI];
   logic [23:0] rdd    [NI];
   logic [7:0]  r_a [NI], g_a [NI], b_a [NI];
   logic        hs_a [NI], vs_a [NI], bl_a [NI], sy_a [NI], fs_a [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      vga_scanout #(
         .H_ACTIVE (HA_P[g]), .H_FP (HF_P[g]), .H_SYNC (HS_P[g]), .H_BP (HB_P[g]),
         .V_ACTIVE (VA_P[g]), .V_FP (VF_P[g]), .V_SYNC (VS_P[g]), .V_BP (VB_P[g]),
         .ADDR_W (19), .RAM_LATENCY (LAT_P[g])
      ) u_dut (
         .vga_clk     (clk),
         .reset_n     (rst_n),
         .rd_addr     (addr_a[g]),
         .rd_data     (rdd[g]),
         .vga_r       (r_a[g]),
         .vga_g       (g_a[g]),
         .vga_b       (b_a[g]),
         .vga_hs      (hs_a[g]),
         .vga_vs      (vs_a[g]),
         .vga_blank_n (bl_a[g]),
         .vga_sync_n  (sy_a[g]),
         .frame_start (fs_a[g])
      );
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s inst%0d got=%h want=%h", nm, i, got, exp);
   endtask

   function automatic int ht(input int i);
      return HA_P[i] + HF_P[i] + HS_P[i] + HB_P[i];
   endfunction

   function automatic int vt(input int i);
      return VA_P[i] + VF_P[i] + VS_P[i] + VB_P[i];
   endfunction

   function automatic bit is_de(input int i, input int h, input int v);
      return (h < HA_P[i]) && (v < VA_P[i]);
   endfunction

   // Expected pins {blank_n, hs, vs, rgb} for counter state (h,v).
   function automatic logic [26:0] pin_exp(input int i, input int h, input int v);
      bit de, hs, vs;
      logic [23:0] rgb;
      de  = is_de(i, h, v);
      hs  = !((h >= HA_P[i] + HF_P[i]) && (h < HA_P[i] + HF_P[i] + HS_P[i]));
      vs  = !((v >= VA_P[i] + VF_P[i]) && (v < VA_P[i] + VF_P[i] + VS_P[i]));
      rgb = de ? 24'(v * HA_P[i] + h) : 24'h0;
      return {de, hs, vs, rgb};
   endfunction

   // rd_addr during state (h,v): the current pixel, or the next one to be read.
   function automatic int addr_exp(input int i, input int h, input int v);
      if (v >= VA_P[i]) return VA_P[i] * HA_P[i];
      if (h < HA_P[i])  return v * HA_P[i] + h;
      return (v + 1) * HA_P[i];
   endfunction

   int          mh [NI], mv [NI];
   bit          wr [NI];
   logic [18:0] ah [NI][5];
   bit          act [NI][5];
   logic [26:0] sbq [NI][$];
   logic        exp_fs [NI];
   logic [18:0] exp_addr [NI];

   // Raster model + RAM model: tracks the counter state, pushes expected pins, echoes addresses.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         #1;
         for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
               mh[i] = 0;
               mv[i] = 0;
               wr[i] = 1'b0;
               sbq[i].delete();
               for (int k = 0; k <= LAT_P[i]; k++) sbq[i].push_back(27'h3000000);
               for (int k = 0; k < 5; k++) begin
                  ah[i][k]  = '0;
                  act[i][k] = 1'b0;
               end
            end else begin
               mh[i]++;
               if (mh[i] == ht(i)) begin
                  mh[i] = 0;
                  mv[i]++;
                  if (mv[i] == vt(i)) begin
                     mv[i] = 0;
                     wr[i] = 1'b1;
                  end
               end
               for (int k = 4; k > 0; k--) begin
                  ah[i][k]  = ah[i][k-1];
                  act[i][k] = act[i][k-1];
               end
            end
            ah[i][0]  = addr_a[i];
            act[i][0] = is_de(i, mh[i], mv[i]);
            sbq[i].push_back(pin_exp(i, mh[i], mv[i]));
            exp_fs[i]   = wr[i] && (mh[i] == 0) && (mv[i] == 0);
            exp_addr[i] = 19'(addr_exp(i, mh[i], mv[i]));
            if (act[i][LAT_P[i]]) rdd[i] = {5'b0, ah[i][LAT_P[i]]};
            else rdd[i] = FILLX_P[i] ? 24'hxxxxxx : 24'hFFFFFF;
         end
      end
   end

   // Monitor: every cycle out of reset, pop the expected pins and compare with the live ones.
   initial begin
      logic [26:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
               if (sbq[i].size() == 0) e = 27'h7FFFFFF;
               else e = sbq[i].pop_front();
               chk("pins", i,
                   64'({bl_a[i], hs_a[i], vs_a[i], r_a[i], g_a[i], b_a[i], sy_a[i], fs_a[i], addr_a[i]}),
                   64'({e, 1'b0, exp_fs[i], exp_addr[i]}));
            end
         end
      end
   end

   initial begin
      int first [NI];
      int br0 [3], bf0 [3], hf0 [3], hr0 [3];
      int nbr, nbf, nhf, nhr, br2, vf2, vr2, nfs;
      int fsc [3];
      logic [18:0] a140, a275;
      logic fs275, pbl0, phs0, pbl2, pvs2;

      rst_n = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++)
         chk("reset_hold", i, 64'({addr_a[i], r_a[i], g_a[i], b_a[i], hs_a[i], vs_a[i], bl_a[i], fs_a[i]}),
             64'({19'd0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0}));

      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int i = 0; i < NI; i++) first[i] = 0;
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NI; i++) if (first[i] == 0 && bl_a[i]) first[i] = e;
      end
      for (int i = 0; i < NI; i++) chk("blank_rise_edge", i, 64'(first[i]), 64'(LAT_P[i] + 1));

      // Reset again in the middle of a line; outputs must drop before the next edge.
      repeat (300) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      for (int i = 0; i < NI; i++)
         chk("reset_async", i, 64'({addr_a[i], r_a[i], g_a[i], b_a[i], hs_a[i], vs_a[i], bl_a[i], fs_a[i]}),
             64'({19'd0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0}));
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;

      for (int k = 0; k < 3; k++) begin
         br0[k] = -1; bf0[k] = -1; hf0[k] = -1; hr0[k] = -1; fsc[k] = -1;
      end
      nbr = 0; nbf = 0; nhf = 0; nhr = 0; nfs = 0;
      br2 = -1; vf2 = -1; vr2 = -1;
      a140 = 'x; a275 = 'x; fs275 = 1'b0;
      pbl0 = 1'b0; phs0 = 1'b1; pbl2 = 1'b0; pvs2 = 1'b1;

      for (int c = 1; c <= 2600; c++) begin
         @(posedge clk);
         #1;
         if (bl_a[0] && !pbl0 && nbr < 3) begin br0[nbr] = c; nbr++; end
         if (!bl_a[0] && pbl0 && nbf < 3) begin bf0[nbf] = c; nbf++; end
         if (!hs_a[0] && phs0 && nhf < 3) begin hf0[nhf] = c; nhf++; end
         if (hs_a[0] && !phs0 && nhr < 3) begin hr0[nhr] = c; nhr++; end
         if (bl_a[2] && !pbl2 && br2 < 0) br2 = c;
         if (!vs_a[2] && pvs2 && vf2 < 0) vf2 = c;
         if (vs_a[2] && !pvs2 && vr2 < 0) vr2 = c;
         if (fs_a[2] && nfs < 3) begin fsc[nfs] = c; nfs++; end
         if (c == 140) a140 = addr_a[2];
         if (c == 275) begin a275 = addr_a[2]; fs275 = fs_a[2]; end
         pbl0 = bl_a[0]; phs0 = hs_a[0]; pbl2 = bl_a[2]; pvs2 = vs_a[2];
      end

      for (int k = 0; k < 3; k++) chk("h_blank_width", 0, 64'(bf0[k] - br0[k]), 64'd640);
      chk("h_hs_fall_offset", 0, 64'(hf0[0] - br0[0]), 64'd656);
      chk("h_hs_period",      0, 64'(hf0[1] - hf0[0]), 64'd800);
      chk("h_hs_period",      0, 64'(hf0[2] - hf0[1]), 64'd800);
      chk("h_hs_low",         0, 64'(hr0[0] - hf0[0]), 64'd96);
      chk("v_vs_offset",      2, 64'(vf2 - br2),       64'd200);
      chk("v_vs_low",         2, 64'(vr2 - vf2),       64'd50);
      chk("fs_first",         2, 64'(fsc[0]),          64'd275);
      chk("fs_period",        2, 64'(fsc[1] - fsc[0]), 64'd275);
      chk("fs_period",        2, 64'(fsc[2] - fsc[1]), 64'd275);
      chk("wrap_last_addr",   2, 64'(a140),            64'd95);
      chk("wrap_next_addr",   2, 64'(a275),            64'd0);
      chk("wrap_fs",          2, 64'(fs275),           64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
